// File: rtl/uart_tx_if.sv
// Address/mode lines of the core data bus as seen by the UART transmitter.
// The tristate data lines stay a plain inout port on the module.
interface uart_tx_if;
    logic [31:0] data_bus_addr;
    logic [1:0]  data_bus_mode;

    modport master (output data_bus_addr, output data_bus_mode);
    modport slave  (input  data_bus_addr, input  data_bus_mode);
endinterface

// File: rtl/uart_tx.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO, programmable divisor and drain interrupt.
// Optional even parity bit when UART_TX_PARITY_EN is defined.
module uart_tx #(
    parameter logic [31:0] base_address = 32'h40C0,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter logic [15:0] DEFAULT_DIV  = 16'd103
) (
    input  logic        clk,
    input  logic        reset,
    uart_tx_if.slave    bus,
    inout  wire  [31:0] data_bus_data,
    output logic        tx_out,
    output logic        tx_irq
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_BAUD   = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    // Bus decode
    logic       hit, rd_hit, wr_hit;
    logic [1:0] reg_sel;

    assign hit     = (bus.data_bus_addr[31:4] == base_address[31:4]);
    assign reg_sel = bus.data_bus_addr[3:2];
    assign rd_hit  = hit && (bus.data_bus_mode == 2'b01);
    assign wr_hit  = hit && (bus.data_bus_mode == 2'b10);

    // Configuration registers
    logic [15:0] baud;
    logic        tx_en, irq_en, parity_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baud   <= DEFAULT_DIV;
            tx_en  <= 1'b0;
            irq_en <= 1'b0;
        end else if (wr_hit && reg_sel == REG_BAUD) begin
            baud <= data_bus_data[15:0];
        end else if (wr_hit && reg_sel == REG_CTRL) begin
            tx_en  <= data_bus_data[0];
            irq_en <= data_bus_data[1];
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            parity_en <= 1'b0;
        else if (wr_hit && reg_sel == REG_CTRL)
            parity_en <= data_bus_data[2];
    end
`else
    assign parity_en = 1'b0;
`endif

    // TX FIFO
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push_req, push, pop, full, empty, overflow;

    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign push_req = wr_hit && (reg_sel == REG_DATA);
    // A pop in the same cycle frees the slot, so a push to a full FIFO is still accepted.
    assign push     = push_req && (!full || pop);

    // NOTE: the storage array has no reset; validity is tracked by count/pointers, which are reset.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= data_bus_data[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_req && !push)
                overflow <= 1'b1;
            else if (wr_hit && reg_sel == REG_STATUS && data_bus_data[3])
                overflow <= 1'b0;
        end
    end

    // Shift engine
    state_t      state, state_next;
    logic [15:0] div_cnt, div_lat;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift;
    logic        bit_end, load, busy, line_d;
`ifdef UART_TX_PARITY_EN
    logic        par_frame, parity_bit;
`endif

    assign bit_end = (div_cnt == div_lat);
    assign busy    = (state != S_IDLE);
    assign pop     = load;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            S_IDLE: begin
                if (tx_en && !empty) begin
                    load       = 1'b1;
                    state_next = S_START;
                end
            end
            S_START: if (bit_end) state_next = S_DATA;
            S_DATA: begin
                if (bit_end && bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    state_next = par_frame ? S_PARITY : S_STOP;
`else
                    state_next = S_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: if (bit_end) state_next = S_STOP;
`endif
            S_STOP: begin
                if (bit_end) begin
                    if (tx_en && !empty) begin
                        load       = 1'b1;
                        state_next = S_START;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        line_d = 1'b1;
        case (state)
            S_START:  line_d = 1'b0;
            S_DATA:   line_d = shift[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: line_d = parity_bit;
`endif
            default:  line_d = 1'b1;
        endcase
    end

    // Divisor and parity mode are latched per frame so mid-frame writes apply to the next one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            div_lat <= '0;
            bit_cnt <= '0;
            shift   <= '0;
        end else if (load) begin
            div_cnt <= '0;
            div_lat <= baud;
            bit_cnt <= '0;
            shift   <= fifo_mem[rd_ptr];
        end else if (busy) begin
            if (bit_end) begin
                div_cnt <= '0;
                if (state == S_DATA) begin
                    shift   <= shift >> 1;
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end else begin
                div_cnt <= div_cnt + 16'd1;
            end
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_frame  <= 1'b0;
            parity_bit <= 1'b0;
        end else if (load) begin
            par_frame  <= parity_en;
            parity_bit <= ^fifo_mem[rd_ptr];
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_out <= 1'b1;
            tx_irq <= 1'b0;
        end else begin
            tx_out <= line_d;
            tx_irq <= irq_en && empty && !busy;
        end
    end

    // Register read mux
    logic [31:0] rd_data;

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            REG_STATUS: rd_data = {16'h0, 8'(count), 4'h0, overflow, empty, full, busy};
            REG_BAUD:   rd_data = {16'h0, baud};
            REG_CTRL:   rd_data = {29'h0, parity_en, irq_en, tx_en};
            default:    rd_data = '0;
        endcase
    end

    assign data_bus_data = rd_hit ? rd_data : 32'bz;

    logic unused_bits;
    assign unused_bits = ^{bus.data_bus_addr[1:0], data_bus_data[31:16]};
endmodule
